// File: rtl/smg_scan_driver.sv
// Time-multiplexed scan driver for a common-anode, active-low multi-digit 7-segment display.
// Data is double-buffered so the shown value only changes at frame boundaries.
module smg_scan_driver #(
  parameter int unsigned CLK_FREQ = 50_000_000,
  parameter int unsigned SCAN_HZ  = 1000,
  parameter int unsigned GAP_CYC  = 16,
  parameter int unsigned DIG_NUM  = 6
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   en,
  input  logic [4*DIG_NUM-1:0]   data_in,
  input  logic [DIG_NUM-1:0]     dp_in,
  input  logic                   data_vld,
  input  logic                   blank_lz,
  output logic [7:0]             seg_out,
  output logic [DIG_NUM-1:0]     sel_out,
  output logic                   frame_done
);

  localparam int unsigned DIV   = CLK_FREQ / SCAN_HZ;
  localparam int unsigned CNT_W = $clog2(DIV);
  localparam int unsigned IDX_W = $clog2(DIG_NUM);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV - 1);
  localparam logic [CNT_W-1:0] GAP_VAL  = CNT_W'(GAP_CYC);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DIG_NUM - 1);

  typedef enum logic [1:0] {
    IDLE,
    BLANK,
    DRIVE
  } state_e;

  state_e                 state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [IDX_W-1:0]       idx_q, idx_d;
  logic [4*DIG_NUM-1:0]   pend_data_q, pend_data_d;
  logic [DIG_NUM-1:0]     pend_dp_q, pend_dp_d;
  logic [4*DIG_NUM-1:0]   act_data_q, act_data_d;
  logic [DIG_NUM-1:0]     act_dp_q, act_dp_d;
  logic [7:0]             seg_q, seg_d;
  logic [DIG_NUM-1:0]     sel_q, sel_d;
  logic                   frame_done_q, frame_done_d;

  logic                   boundary;
  logic [DIG_NUM-1:0]     zero_run;
  logic [3:0]             cur_nib;
  logic                   suppress;

  function automatic logic [6:0] enc7(input logic [3:0] nib);
    logic [6:0] s;
    case (nib)
      4'h0: s = 7'h40;
      4'h1: s = 7'h79;
      4'h2: s = 7'h24;
      4'h3: s = 7'h30;
      4'h4: s = 7'h19;
      4'h5: s = 7'h12;
      4'h6: s = 7'h02;
      4'h7: s = 7'h78;
      4'h8: s = 7'h00;
      4'h9: s = 7'h10;
      4'hA: s = 7'h08;
      4'hB: s = 7'h03;
      4'hC: s = 7'h46;
      4'hD: s = 7'h21;
      4'hE: s = 7'h06;
      default: s = 7'h0E;
    endcase
    return s;
  endfunction

  // zero_run[i] is set when digit i and every digit above it hold zero.
  always_comb begin
    logic all_zero;
    all_zero = 1'b1;
    zero_run = '0;
    for (int unsigned k = 0; k < DIG_NUM; k++) begin
      all_zero = all_zero & (act_data_q[4*(DIG_NUM-1-k) +: 4] == 4'h0);
      zero_run[DIG_NUM-1-k] = all_zero;
    end
  end

  assign cur_nib  = act_data_q[{idx_q, 2'b00} +: 4];
  assign suppress = blank_lz && (idx_q != '0) && zero_run[idx_q];
  assign boundary = (state_q != IDLE) && (cnt_q == CNT_LAST) && (idx_q == IDX_LAST);

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    idx_d        = idx_q;
    pend_data_d  = pend_data_q;
    pend_dp_d    = pend_dp_q;
    act_data_d   = act_data_q;
    act_dp_d     = act_dp_q;
    seg_d        = 8'hFF;
    sel_d        = '1;
    frame_done_d = boundary;

    if (data_vld) begin
      pend_data_d = data_in;
      pend_dp_d   = dp_in;
    end

    // A strobe landing on the boundary bypasses pending straight into active.
    if (boundary) begin
      act_data_d = data_vld ? data_in : pend_data_q;
      act_dp_d   = data_vld ? dp_in   : pend_dp_q;
    end

    if (!en) begin
      state_d = IDLE;
      cnt_d   = '0;
      idx_d   = '0;
    end else if (state_q == IDLE) begin
      state_d = BLANK;
      cnt_d   = '0;
      idx_d   = '0;
    end else begin
      if (cnt_q == CNT_LAST) begin
        cnt_d = '0;
        idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + IDX_W'(1);
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
      state_d = (cnt_d < GAP_VAL) ? BLANK : DRIVE;
    end

    // Gating on en blanks the pins on the same edge the scan drops to IDLE.
    if (en && state_q == DRIVE) begin
      sel_d[idx_q] = 1'b0;
      seg_d        = {~act_dp_q[idx_q], suppress ? 7'h7F : enc7(cur_nib)};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      idx_q        <= '0;
      pend_data_q  <= '0;
      pend_dp_q    <= '0;
      act_data_q   <= '0;
      act_dp_q     <= '0;
      seg_q        <= 8'hFF;
      sel_q        <= '1;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      idx_q        <= idx_d;
      pend_data_q  <= pend_data_d;
      pend_dp_q    <= pend_dp_d;
      act_data_q   <= act_data_d;
      act_dp_q     <= act_dp_d;
      seg_q        <= seg_d;
      sel_q        <= sel_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign seg_out    = seg_q;
  assign sel_out    = sel_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_smg_scan_driver.sv
// Scoreboard bench for smg_scan_driver: stimulus pushes hand-computed digit slots,
// a monitor pops one entry each time a driven digit slot ends.
module tb_smg_scan_driver;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        en;
  logic [23:0] data_in;
  logic [5:0]  dp_in;
  logic        data_vld;
  logic        blank_lz;
  logic [7:0]  seg_out;
  logic [5:0]  sel_out;
  logic        frame_done;

  smg_scan_driver #(
    .CLK_FREQ(1000),
    .SCAN_HZ (100),
    .GAP_CYC (2),
    .DIG_NUM (6)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (en),
    .data_in   (data_in),
    .dp_in     (dp_in),
    .data_vld  (data_vld),
    .blank_lz  (blank_lz),
    .seg_out   (seg_out),
    .sel_out   (sel_out),
    .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [5:0] sel;
    logic [7:0] seg;
    int         len;
  } slot_t;

  slot_t exp_q[$];
  int    n_chk = 0;
  int    n_err = 0;
  logic  mon_on = 1'b1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic push(input int idx, input logic [7:0] seg, input int len);
    slot_t s;
    logic [5:0] one;
    one   = 6'b000001;
    s.sel = ~(one << idx);
    s.seg = seg;
    s.len = len;
    exp_q.push_back(s);
  endtask

  // Expected segments for digits 0..5 in scan order, all full-length slots.
  task automatic push_frame(input logic [7:0] s0, input logic [7:0] s1, input logic [7:0] s2,
                            input logic [7:0] s3, input logic [7:0] s4, input logic [7:0] s5);
    push(0, s0, 8); push(1, s1, 8); push(2, s2, 8);
    push(3, s3, 8); push(4, s4, 8); push(5, s5, 8);
  endtask

  task automatic wait_frame(input string name, input int exp_cyc);
    int c;
    c = 0;
    do begin
      tick(1);
      c++;
    end while (!frame_done && c < 200);
    check(name, c, exp_cyc);
  endtask

  // Monitor: a slot is a run of identical non-blank outputs; it is scored when sel returns high.
  logic       in_slot = 1'b0;
  logic [5:0] cur_sel;
  logic [7:0] cur_seg;
  int         cur_len;

  always @(negedge clk) begin
    if (mon_on && rst_n) begin
      if (sel_out != 6'h3F) begin
        if (!in_slot) begin
          in_slot = 1'b1;
          cur_sel = sel_out;
          cur_seg = seg_out;
          cur_len = 1;
        end else if (sel_out == cur_sel && seg_out == cur_seg) begin
          cur_len++;
        end else begin
          check("slot_stable", {18'd0, sel_out, seg_out}, {18'd0, cur_sel, cur_seg});
          cur_sel = sel_out;
          cur_seg = seg_out;
          cur_len = 1;
        end
      end else if (in_slot) begin
        in_slot = 1'b0;
        if (exp_q.size() == 0) begin
          check("unexpected_slot", {24'd0, cur_sel}, 32'h3F);
        end else begin
          slot_t e;
          e = exp_q.pop_front();
          check("slot_sel", {26'd0, cur_sel}, {26'd0, e.sel});
          check("slot_seg", {24'd0, cur_seg}, {24'd0, e.seg});
          check("slot_len", cur_len, e.len);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n    = 1'b0;
    en       = 1'b0;
    data_in  = '0;
    dp_in    = '0;
    data_vld = 1'b0;
    blank_lz = 1'b1;
    tick(3);
    check("rst_seg", {24'd0, seg_out}, 32'hFF);
    check("rst_sel", {26'd0, sel_out}, 32'h3F);
    check("rst_fd", {31'd0, frame_done}, 32'h0);
    rst_n = 1'b1;
    tick(2);
    check("idle_sel", {26'd0, sel_out}, 32'h3F);
    check("idle_seg", {24'd0, seg_out}, 32'hFF);

    // Frame 0: active still zero with blank_lz=1, only digit 0 shows "0".
    push_frame(8'hC0, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF);
    en       = 1'b1;
    data_vld = 1'b1;
    data_in  = 24'h12AB3F;
    dp_in    = 6'b000000;
    tick(1);
    data_vld = 1'b0;
    wait_frame("frame0_period", 60);

    // Frame 1 shows 12AB3F; a mid-frame strobe must not tear it.
    push_frame(8'h8E, 8'hB0, 8'h83, 8'h88, 8'hA4, 8'hF9);
    tick(25);
    data_vld = 1'b1;
    data_in  = 24'h000400;
    dp_in    = 6'b000000;
    tick(1);
    data_vld = 1'b0;
    wait_frame("frame1_period", 34);

    // Frame 2: 000400 with suppression.
    push_frame(8'hC0, 8'hC0, 8'h99, 8'hFF, 8'hFF, 8'hFF);
    tick(25);
    data_vld = 1'b1;
    data_in  = 24'h000000;
    dp_in    = 6'b000100;
    tick(1);
    data_vld = 1'b0;
    wait_frame("frame2_period", 34);

    // Frame 3: zeros, no suppression, decimal point on digit 2.
    blank_lz = 1'b0;
    push_frame(8'hC0, 8'hC0, 8'h40, 8'hC0, 8'hC0, 8'hC0);
    tick(25);
    data_vld = 1'b1;
    data_in  = 24'h12AB3F;
    dp_in    = 6'b000000;
    tick(1);
    data_vld = 1'b0;
    wait_frame("frame3_period", 34);

    // Frame 4: disable while digit 3 is driving (after three drive cycles).
    push(0, 8'h8E, 8); push(1, 8'hB0, 8); push(2, 8'h83, 8); push(3, 8'h88, 3);
    tick(35);
    en = 1'b0;
    tick(1);
    check("dis_sel", {26'd0, sel_out}, 32'h3F);
    check("dis_seg", {24'd0, seg_out}, 32'hFF);
    tick(4);
    check("dis_fd", {31'd0, frame_done}, 32'h0);

    // Re-enable: restart at digit 0 after two blank clocks with retained data.
    push_frame(8'h8E, 8'hB0, 8'h83, 8'h88, 8'hA4, 8'hF9);
    en = 1'b1;
    tick(1);
    tick(2);
    check("reen_blank_sel", {26'd0, sel_out}, 32'h3F);
    tick(1);
    check("reen_first_sel", {26'd0, sel_out}, 32'h3E);
    tick(22);
    data_vld = 1'b1;
    data_in  = 24'h000000;
    tick(1);
    data_vld = 1'b0;
    tick(33);
    // Strobe on the boundary cycle goes straight to active.
    data_vld = 1'b1;
    data_in  = 24'hFFFFFF;
    tick(1);
    data_vld = 1'b0;
    check("coincide_fd", {31'd0, frame_done}, 32'h1);

    push_frame(8'h8E, 8'h8E, 8'h8E, 8'h8E, 8'h8E, 8'h8E);
    push_frame(8'h8E, 8'h8E, 8'h8E, 8'h8E, 8'h8E, 8'h8E);
    wait_frame("frame6_period", 60);
    wait_frame("frame7_period", 60);
    tick(3);
    check("queue_drained", exp_q.size(), 0);

    // Asynchronous reset in the middle of a digit slot.
    mon_on = 1'b0;
    tick(30);
    check("pre_rst_sel", {26'd0, sel_out}, 32'h37);
    rst_n = 1'b0;
    #1;
    check("mid_rst_sel", {26'd0, sel_out}, 32'h3F);
    check("mid_rst_seg", {24'd0, seg_out}, 32'hFF);
    check("mid_rst_fd", {31'd0, frame_done}, 32'h0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
